// File: rtl/cpu_pkg.sv
// cpu_pkg: PC-mode encodings, instruction field layout and opcodes shared by the fetch unit and the controller
package cpu_pkg;
  localparam logic [1:0] PC_INCREMENT = 2'b00;
  localparam logic [1:0] PC_OFFSET = 2'b01;
  localparam logic [1:0] PC_ABSOLUTE = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;
  localparam int OPCODE_LSB = 12;
  localparam int RDEST_LSB = 8;
  localparam int OPEXT_LSB = 4;
  localparam int RSRC_LSB = 0;
  localparam int IMM8_LSB = 0;
  localparam int FIELD_W = 4;
  localparam int IMM8_W = 8;
  localparam logic [3:0] OP_REG = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LOAD_STORE = 4'h4;
  localparam logic [3:0] OP_BCOND = 4'hc;
  localparam logic [3:0] OP_MOVI = 4'hd;
  typedef enum logic {IDLE, REQ} fetch_state_t;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: next-PC mux (increment, signed offset, absolute) and JAL link address
module pc_next_logic import cpu_pkg::*; #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [1:0]            pc_addr_mode,
  input  logic [IMM8_W-1:0]     imm8,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic [ADDR_WIDTH-1:0] link_addr
);
  logic [ADDR_WIDTH-1:0] offset;
  assign offset = {{(ADDR_WIDTH-IMM8_W){imm8[IMM8_W-1]}}, imm8};
  assign link_addr = pc + ADDR_WIDTH'(1);
  always_comb begin
    pc_next = pc_addr_mode == PC_INCREMENT ? link_addr :
              pc_addr_mode == PC_OFFSET    ? pc + offset :
              pc_addr_mode == PC_ABSOLUTE  ? jump_target : pc;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, request/ack instruction fetch FSM and instruction register with field decode
module instr_fetch_unit import cpu_pkg::*; #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  next_instr,
  input  logic                  pc_en,
  input  logic [1:0]            pc_addr_mode,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  busy,
  output logic [3:0]            opcode,
  output logic [3:0]            rdest,
  output logic [3:0]            opcode_ext,
  output logic [3:0]            rsrc,
  output logic [7:0]            imm8,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] link_addr
);
  fetch_state_t state, state_next;
  logic [ADDR_WIDTH-1:0] pc_next;
  pc_next_logic #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
    .pc(pc),
    .pc_addr_mode(pc_addr_mode),
    .imm8(imm8),
    .jump_target(jump_target),
    .pc_next(pc_next),
    .link_addr(link_addr)
  );
  // PC only moves in IDLE so the address stays stable for the whole request
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && pc_en) pc <= pc_next;
      if (state == REQ && mem_ack) instr <= mem_rdata;
      instr_valid <= state == REQ && mem_ack;
    end
  end
  always_comb begin
    state_next = state;
    mem_req = 1'b0;
    busy = 1'b0;
    state_next = state == IDLE ? (next_instr ? REQ : IDLE) : (mem_ack ? IDLE : REQ);
    mem_req = state == REQ;
    busy = state == REQ;
  end
  assign mem_addr = pc;
  assign opcode = instr[OPCODE_LSB +: FIELD_W];
  assign rdest = instr[RDEST_LSB +: FIELD_W];
  assign opcode_ext = instr[OPEXT_LSB +: FIELD_W];
  assign rsrc = instr[RSRC_LSB +: FIELD_W];
  assign imm8 = instr[IMM8_LSB +: IMM8_W];
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter and instruction-register stage that sits directly upstream of `CPU_Controller`. It holds the PC and fetches the instruction at the PC through a request/acknowledge memory port. It latches that instruction and presents the decoded `opcode`/`opcode_ext` and operand fields to the controller. It also applies the controller's `pc_en`/`pc_addr_mode` commands to compute the next PC (increment, signed branch offset, absolute jump) and supplies the JAL link address.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, PC / memory address width
- `DATA_WIDTH`, 16, instruction width (fixed field layout assumes 16)
- `RESET_PC`, 16'h0000, PC value loaded on reset

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `next_instr`  in  1  controller request: fetch instruction at current PC
- `pc_en`  in  1  controller: update PC this cycle
- `pc_addr_mode`  in  2  00 increment, 01 offset, 10 absolute, 11 reserved
- `jump_target`  in  ADDR_WIDTH  Rtarget value from register file (absolute mode)
- `mem_rdata`  in  DATA_WIDTH  instruction memory read data
- `mem_ack`  in  1  memory: `mem_rdata` valid this cycle
- `mem_req`  out  1  memory read request, held until `mem_ack`
- `mem_addr`  out  ADDR_WIDTH  always equals `pc`
- `instr`  out  DATA_WIDTH  instruction register
- `instr_valid`  out  1  one-cycle pulse: `instr` newly loaded
- `busy`  out  1  fetch in progress
- `opcode`  out  4  `instr[15:12]`
- `rdest`  out  4  `instr[11:8]`
- `opcode_ext`  out  4  `instr[7:4]`
- `rsrc`  out  4  `instr[3:0]`
- `imm8`  out  8  `instr[7:0]`
- `pc`  out  ADDR_WIDTH  address of current instruction
- `link_addr`  out  ADDR_WIDTH  `pc + 1`, JAL write-back source

## Operation
- FSM states: IDLE, REQ.
  - IDLE: `mem_req`=0, `busy`=0. `next_instr`=1 moves the FSM to REQ.
  - REQ: `mem_req`=1, `busy`=1. On `mem_ack`, `instr` <= `mem_rdata` and `instr_valid` <= 1 in the next cycle, then return to IDLE. Without `mem_ack`, stay in REQ indefinitely.
- `next_instr` is ignored while in REQ; it does not queue.
- PC update (only in IDLE with `pc_en`=1):
  - 00: `pc` <= `pc`+1
  - 01: `pc` <= `pc` + sign_extend(`imm8`)
  - 10: `pc` <= `jump_target`
  - 11: `pc` unchanged
- `pc_en` is ignored in REQ, so `mem_addr` is stable for the whole request.
- `pc_en` and `next_instr` asserted in the same IDLE cycle: the PC updates first, and the fetch in REQ uses the new PC.
- All PC arithmetic is modulo 2^ADDR_WIDTH: FFFF+1 = 0000; offset FF (-1) from 0000 gives FFFF.
- `instr` holds its value until the next `mem_ack`; decoded fields are purely combinational from `instr`.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0 (`opcode`/`opcode_ext`=0), `instr_valid`=0, `mem_req`=0, `busy`=0, state IDLE, `link_addr`=`RESET_PC`+1.
- Zero-wait memory fetch latency:
  - cycle N: `next_instr`
  - cycle N+1: `mem_req`=1, `mem_ack`=1
  - cycle N+2: `instr` updated, `instr_valid`=1
  - Each wait cycle without `mem_ack` adds one cycle.
- `instr_valid` is high for exactly one cycle per completed fetch.
- Reset asserted in REQ: the FSM returns to IDLE and `mem_req`=0 on the next edge. A late `mem_ack` arriving in IDLE is ignored and `instr` is unchanged.
- A PC update takes effect on the edge after `pc_en`; `mem_addr` and `link_addr` follow in the same cycle.

## Structure
- Shared `cpu_pkg`:
  - PC_INCREMENT/PC_OFFSET/PC_ABSOLUTE constants, shared with `CPU_Controller`
  - instruction field bit positions
  - opcode localparams
- One sub-module, `pc_next_logic`: combinational next-PC mux and adders, producing `pc_next` and `link_addr`.
- FSM, PC register and IR live in `instr_fetch_unit`.

## Test plan
- Reset then `next_instr` with `mem_rdata`=16'h0315 and ack in the first REQ cycle -> `instr_valid` pulses at N+2; `opcode`=0, `rdest`=3, `opcode_ext`=1, `rsrc`=5; `pc`=0000.
- Memory with 3 wait cycles -> `mem_req` high for 4 cycles, `busy` high throughout, `mem_addr` stable, `instr_valid` at N+5. A `pc_en` pulse during REQ leaves `pc` unchanged.
- `pc`=0010, `imm8`=FC, mode 01 -> `pc`=000C. Mode 00 from FFFF -> 0000. Mode 10 with `jump_target`=1234 -> 1234, `link_addr`=1235. Mode 11 -> `pc` unchanged.
- `pc_en` (mode 00) and `next_instr` in the same cycle at `pc`=0004 -> REQ issues `mem_addr`=0005.
- Reset asserted in the second REQ cycle, then `mem_ack` in the following cycle -> `mem_req`=0, `instr` stays 0, no `instr_valid`, `pc`=`RESET_PC`.
